sort_out_serializer: RTL and testbench
======================================

Name: sort_out_serializer

Overview:
- Sits directly downstream of the pipelined four-element sort unit.
- Captures each sorted 4-element bundle on a one-cycle valid pulse and buffers it.
- Streams the elements out one per transfer, ascending order (index 0 first), on a val/rdy interface.
- The sort unit has no backpressure, so this block buffers whole bundles. On overflow it drops the incoming bundle and flags the loss.

Parameters:
p_nbits, 8, element width in bits
p_nbundles, 2, bundle buffer depth; power of two, >= 2

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
in_val  input  1  one-cycle pulse: sorted bundle present on in0..in3
in0  input  p_nbits  sorted element 0 (smallest)
in1  input  p_nbits  sorted element 1
in2  input  p_nbits  sorted element 2
in3  input  p_nbits  sorted element 3 (largest)
out_val  output  1  out_msg valid
out_rdy  input  1  consumer ready
out_msg  output  p_nbits  current element
out_last  output  1  out_msg is element 3 of its bundle
overflow  output  1  sticky: at least one bundle dropped since reset
occupancy  output  $clog2(p_nbundles)+1  bundles currently buffered (includes the partially drained head)

Behaviour:
- Reset: reset is synchronous and active-low; clock is clk.
- While reset==0 at posedge, the block clears:
  - FIFO pointers and occupancy (to 0)
  - element index (to 0)
  - overflow (to 0)
  - out_val (to 0)
- Reset mid-drain discards all buffered bundles, including a partially sent one. The first transfer after reset is element 0 of a newly pushed bundle.
- Bundle FIFO:
  - Circular buffer of p_nbundles entries; each entry holds 4 x p_nbits.
  - Push at posedge when in_val==1 and the buffer is not full.
  - Read/write pointers wrap modulo p_nbundles.
- Output datapath:
  - out_val = (occupancy != 0).
  - out_msg = head[idx]; out_last = (idx == 3).
  - When out_val==0: out_msg=0 and out_last=0.
- Transfer occurs when out_val && out_rdy at posedge:
  - idx < 3: idx increments.
  - idx == 3: head bundle pops and idx wraps to 0.
- Output stability: while out_val==1 && out_rdy==0, out_msg and out_last hold stable.
- Latency: a bundle pushed at posedge t into an empty buffer gives out_val=1 with element 0 in the cycle after t. There is no combinational in_val->out_val path.
- Throughput: with out_rdy held high, one element per cycle. Back-to-back bundles spaced >= 4 cycles stream with no bubbles.
- Full with simultaneous final pop:
  - Condition: in_val==1 while full, and the same cycle is a transfer with idx==3.
  - The bundle is accepted (pop and push together), occupancy is unchanged, and overflow is not set.
- Full, otherwise: in_val==1 while full with no final pop drops the whole incoming bundle (never partial). overflow becomes 1 at that posedge and stays 1 until reset.
- in_val==1 while occupancy==0: the bundle is pushed normally. No bypass path.
- out_rdy is ignored while out_val==0.
- Assertions (simulation only): in_val, out_rdy and out_val are never X outside reset; occupancy <= p_nbundles.

Decomposition:
- Shared package sort_pkg:
  - constant SORT_NELEMS = 4
  - typedef sort_idx_t (2-bit element index)
  - typedef for the bundle array type (parameterised by width via a macro, or by a local typedef in the module)
- One natural sub-module: sort_bundle_fifo, a generic p_nbundles-deep FIFO of 4*p_nbits-wide entries.
  - Interface: enq_val/enq_rdy, deq_val/deq_rdy, occupancy.
  - Supports same-cycle enq and deq when full.
- The top level holds the element index counter, the output mux, and the overflow/drop logic.

Test Plan:
- Single bundle, p_nbits=8: in_val pulse with {03,05,07,09}, out_rdy=1 -> out_msg 03,05,07,09 on the next four cycles; out_last=1 only on 09; then out_val=0, occupancy=0.
- Backpressure: same bundle with out_rdy=0 on the second and third cycles of out_val -> out_msg holds 05 for both stalled cycles; full sequence still 03,05,07,09; no element duplicated or lost.
- Overflow, p_nbundles=2: out_rdy=0, bundles {1,2,3,4}, {5,6,7,8}, {9,A,B,C} on consecutive pulses -> occupancy=2; overflow=1 after the third pulse. Then out_rdy=1 -> output 1..8 only, overflow remains 1.
- Simultaneous pop/push when full: two bundles buffered, head drained to idx=3. A third bundle {D,E,F,10} arrives on the cycle of the final transfer -> accepted; occupancy stays 2; overflow=0; {D,E,F,10} later emitted in order.
- Reset mid-drain: after element 05 of {03,05,07,09} is transferred, drive reset=0 for one cycle -> out_val=0, occupancy=0, overflow=0. The next bundle {20,21,22,23} emits starting at 20.
- Streaming: bundles every 4 cycles for 8 bundles, out_rdy=1 -> out_val continuously 1 for 32 cycles; out_last every 4th cycle; no overflow.

Source files
------------

// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the four-element sort unit and its output stage.
//   SORT_NELEMS : number of elements in one sorted bundle
//   sort_idx_t  : index of an element within a bundle (0 = smallest)
// The bundle array type depends on the element width, so each module that
// needs it declares a local typedef built from SORT_NELEMS.
// -----------------------------------------------------------------------------
package sort_pkg;

    localparam int SORT_NELEMS = 4;

    typedef logic [1:0] sort_idx_t;

    localparam sort_idx_t SORT_IDX_LAST = sort_idx_t'(SORT_NELEMS - 1);

endpackage

// File: rtl/sort_bundle_fifo.sv
// -----------------------------------------------------------------------------
// sort_bundle_fifo
// Circular FIFO of p_depth entries, each p_width bits wide.
// Ports:
//   clk, reset          : clock, synchronous active-low reset (control only)
//   enq_val/enq_rdy     : enqueue handshake, enq_msg is the entry written
//   deq_val/deq_rdy     : dequeue handshake, deq_msg is the head entry
//   occupancy           : number of entries currently stored
// When full, an enqueue is still accepted if a dequeue happens in the same
// cycle, so a full FIFO that is being drained never loses a slot.
// -----------------------------------------------------------------------------
module sort_bundle_fifo #(
    parameter int p_width = 32,
    parameter int p_depth = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [p_width-1:0]         enq_msg,
    output logic                       deq_val,
    input  logic                       deq_rdy,
    output logic [p_width-1:0]         deq_msg,
    output logic [$clog2(p_depth):0]   occupancy
);

    localparam int c_aw = $clog2(p_depth);
    localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(p_depth);
    localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    logic [p_width-1:0] mem_q [p_depth];
    logic [c_aw-1:0]    wptr_q, wptr_d;
    logic [c_aw-1:0]    rptr_q, rptr_d;
    logic [c_aw:0]      count_q, count_d;
    logic               enq_fire, deq_fire;

    assign deq_val   = (count_q != '0);
    assign deq_msg   = mem_q[rptr_q];
    assign deq_fire  = deq_val && deq_rdy;
    assign enq_rdy   = (count_q != c_depth) || deq_fire;
    assign enq_fire  = enq_val && enq_rdy;
    assign occupancy = count_q;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq_fire) wptr_d = wptr_q + c_ptr_one;
        if (deq_fire) rptr_d = rptr_q + c_ptr_one;
        if (enq_fire && !deq_fire)      count_d = count_q + c_cnt_one;
        else if (!enq_fire && deq_fire) count_d = count_q - c_cnt_one;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[wptr_q] <= enq_msg;
    end

`ifndef SYNTHESIS
    a_occ_bound: assert property (@(posedge clk) disable iff (!reset)
        count_q <= c_depth);
`endif

endmodule

// File: rtl/sort_out_serializer.sv
// -----------------------------------------------------------------------------
// sort_out_serializer
// Buffers sorted 4-element bundles from the sort unit and streams them out
// one element per transfer, smallest first, on a val/rdy interface.
// Ports:
//   clk, reset              : clock, synchronous active-low reset
//   in_val, in0..in3        : one-cycle bundle pulse, in0 smallest
//   out_val/out_rdy/out_msg : element stream; out_last marks element 3
//   overflow                : sticky, a bundle was dropped since reset
//   occupancy               : bundles buffered, including the draining head
// The sort unit cannot be stalled, so a bundle arriving while the buffer is
// full is dropped whole, unless the head's final element leaves that cycle.
// -----------------------------------------------------------------------------
module sort_out_serializer
    import sort_pkg::*;
#(
    parameter int p_nbits    = 8,
    parameter int p_nbundles = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_val,
    input  logic [p_nbits-1:0]            in0,
    input  logic [p_nbits-1:0]            in1,
    input  logic [p_nbits-1:0]            in2,
    input  logic [p_nbits-1:0]            in3,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [p_nbits-1:0]            out_msg,
    output logic                          out_last,
    output logic                          overflow,
    output logic [$clog2(p_nbundles):0]   occupancy
);

    typedef logic [SORT_NELEMS-1:0][p_nbits-1:0] bundle_t;

    bundle_t   enq_bundle;
    bundle_t   head_bundle;
    logic      enq_rdy;
    logic      deq_val;
    logic      deq_rdy;
    logic      xfer;
    logic      at_last;
    sort_idx_t idx_q, idx_d;
    logic      overflow_q, overflow_d;

    assign enq_bundle = {in3, in2, in1, in0};

    sort_bundle_fifo #(
        .p_width (SORT_NELEMS * p_nbits),
        .p_depth (p_nbundles)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_val   (in_val),
        .enq_rdy   (enq_rdy),
        .enq_msg   (enq_bundle),
        .deq_val   (deq_val),
        .deq_rdy   (deq_rdy),
        .deq_msg   (head_bundle),
        .occupancy (occupancy)
    );

    assign at_last = (idx_q == SORT_IDX_LAST);
    assign xfer    = deq_val && out_rdy;
    // The head bundle leaves only with its last element.
    assign deq_rdy = xfer && at_last;

    assign out_val  = deq_val;
    assign out_msg  = deq_val ? head_bundle[idx_q] : '0;
    assign out_last = deq_val && at_last;
    assign overflow = overflow_q;

    always_comb begin
        idx_d      = idx_q;
        overflow_d = overflow_q;
        if (xfer) idx_d = at_last ? '0 : idx_q + sort_idx_t'(1);
        // enq_rdy already accounts for a same-cycle final pop.
        if (in_val && !enq_rdy) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

`ifndef SYNTHESIS
    a_no_x: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown({in_val, out_rdy, out_val}));
`endif

endmodule

// File: tb/tb_sort_out_serializer.sv
module tb_sort_out_serializer;

    localparam int NB   = 8;
    localparam int NBUN = 2;
    localparam int OW   = $clog2(NBUN) + 1;
    localparam int VW   = NB + OW + 3;

    typedef logic [3:0][NB-1:0] bund_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_val = 1'b0;
    logic          out_rdy = 1'b0;
    logic [NB-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic          out_val, out_last, overflow;
    logic [NB-1:0] out_msg;
    logic [OW-1:0] occupancy;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sort_out_serializer #(.p_nbits(NB), .p_nbundles(NBUN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .out_last  (out_last),
        .overflow  (overflow),
        .occupancy (occupancy)
    );

    // Reference model: a queue of whole bundles, the position within the
    // head bundle, and a sticky loss flag.
    bund_t mq[$];
    int    midx = 0;
    bit    movf = 1'b0;

    always @(posedge clk) begin
        bit xfer, pop, acc;
        if (!reset) begin
            mq.delete();
            midx = 0;
            movf = 1'b0;
        end else begin
            xfer = (mq.size() != 0) && out_rdy;
            pop  = xfer && (midx == 3);
            acc  = in_val && ((mq.size() < NBUN) || pop);
            if (in_val && !acc) movf = 1'b1;
            if (xfer) begin
                if (pop) begin
                    void'(mq.pop_front());
                    midx = 0;
                end else begin
                    midx++;
                end
            end
            if (acc) mq.push_back({in3, in2, in1, in0});
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic          v;
        logic [NB-1:0] m;
        v = (mq.size() != 0);
        m = '0;
        if (v) m = mq[0][midx];
        return {v, m, v && (midx == 3), OW'(mq.size()), movf};
    endfunction

    task automatic set_bundle(input bund_t b);
        in0 = b[0]; in1 = b[1]; in2 = b[2]; in3 = b[3];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (out_val !== 1'b0) begin failed++; $display("FAIL reset_out_val act=%b exp=0", out_val); end
        tests++; if (occupancy !== '0) begin failed++; $display("FAIL reset_occ act=%0d exp=0", occupancy); end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL reset_ovf act=%b exp=0", overflow); end
        tests++; if ({out_msg, out_last} !== '0) begin failed++; $display("FAIL reset_msg act=%h/%b exp=0/0", out_msg, out_last); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (out_val !== 1'b0) begin failed++; $display("FAIL reset_idle act=%b exp=0", out_val); end
    endtask

    task automatic test_single();
        logic [NB-1:0] w [4] = '{8'h03, 8'h05, 8'h07, 8'h09};
        logic [NB-1:0] got[$];
        logic [NB-1:0] a, last_msg;
        int nlast = 0;
        do_reset();
        @(negedge clk);
        set_bundle({8'h09, 8'h07, 8'h05, 8'h03}); in_val = 1'b1; out_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_val = 1'b0;
            tests++;
            if ({out_val, out_msg, out_last, occupancy, overflow} !== exp_vec()) begin
                failed++; $display("FAIL single_cyc%0d act=%h exp=%h", c, {out_val, out_msg, out_last, occupancy, overflow}, exp_vec());
            end
            if (c == 0) begin
                tests++; if ({out_val, out_msg} !== {1'b1, 8'h03}) begin failed++; $display("FAIL single_latency act=%b/%h exp=1/03", out_val, out_msg); end
            end
            if (out_val && out_last) begin nlast++; last_msg = out_msg; end
            if (out_val && out_rdy) got.push_back(out_msg);
        end
        tests++; if (got.size() != 4) begin failed++; $display("FAIL single_count act=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            a = 'x; if (i < got.size()) a = got[i];
            tests++; if (a !== w[i]) begin failed++; $display("FAIL single_elem%0d act=%h exp=%h", i, a, w[i]); end
        end
        tests++; if (nlast != 1 || last_msg !== 8'h09) begin failed++; $display("FAIL single_last act=%0d/%h exp=1/09", nlast, last_msg); end
        tests++; if ({out_val, occupancy} !== '0) begin failed++; $display("FAIL single_empty act=%b/%0d exp=0/0", out_val, occupancy); end
    endtask

    task automatic test_backpressure();
        logic [NB-1:0] w [4] = '{8'h03, 8'h05, 8'h07, 8'h09};
        logic [NB-1:0] got[$];
        logic [NB-1:0] a;
        do_reset();
        @(negedge clk);
        set_bundle({8'h09, 8'h07, 8'h05, 8'h03}); in_val = 1'b1; out_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_val = 1'b0;
            tests++;
            if ({out_val, out_msg, out_last, occupancy, overflow} !== exp_vec()) begin
                failed++; $display("FAIL bp_cyc%0d act=%h exp=%h", c, {out_val, out_msg, out_last, occupancy, overflow}, exp_vec());
            end
            out_rdy = !(c == 1 || c == 2);
            if (c == 1 || c == 2) begin
                tests++; if ({out_val, out_msg, out_last} !== {1'b1, 8'h05, 1'b0}) begin
                    failed++; $display("FAIL bp_hold%0d act=%b/%h/%b exp=1/05/0", c, out_val, out_msg, out_last);
                end
            end
            if (out_val && out_rdy) got.push_back(out_msg);
        end
        tests++; if (got.size() != 4) begin failed++; $display("FAIL bp_count act=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            a = 'x; if (i < got.size()) a = got[i];
            tests++; if (a !== w[i]) begin failed++; $display("FAIL bp_elem%0d act=%h exp=%h", i, a, w[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [NB-1:0] got[$];
        logic [NB-1:0] a;
        do_reset();
        @(negedge clk);
        set_bundle({8'h04, 8'h03, 8'h02, 8'h01}); in_val = 1'b1;
        @(negedge clk);
        set_bundle({8'h08, 8'h07, 8'h06, 8'h05});
        @(negedge clk);
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL ovf_early act=%b exp=0", overflow); end
        set_bundle({8'h0C, 8'h0B, 8'h0A, 8'h09});
        @(negedge clk);
        in_val = 1'b0;
        tests++; if (occupancy !== OW'(2)) begin failed++; $display("FAIL ovf_occ act=%0d exp=2", occupancy); end
        tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_flag act=%b exp=1", overflow); end
        out_rdy = 1'b1;
        if (out_val && out_rdy) got.push_back(out_msg);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if ({out_val, out_msg, out_last, occupancy, overflow} !== exp_vec()) begin
                failed++; $display("FAIL ovf_cyc%0d act=%h exp=%h", c, {out_val, out_msg, out_last, occupancy, overflow}, exp_vec());
            end
            if (out_val && out_rdy) got.push_back(out_msg);
        end
        tests++; if (got.size() != 8) begin failed++; $display("FAIL ovf_count act=%0d exp=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            a = 'x; if (i < got.size()) a = got[i];
            tests++; if (a !== NB'(i + 1)) begin failed++; $display("FAIL ovf_elem%0d act=%h exp=%h", i, a, NB'(i + 1)); end
        end
        tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_sticky act=%b exp=1", overflow); end
    endtask

    task automatic test_simul_pop_push();
        logic [NB-1:0] got[$];
        logic [NB-1:0] a;
        bit sent = 1'b0;
        bit chk_next = 1'b0;
        do_reset();
        @(negedge clk);
        set_bundle({8'h04, 8'h03, 8'h02, 8'h01}); in_val = 1'b1;
        @(negedge clk);
        set_bundle({8'h08, 8'h07, 8'h06, 8'h05});
        @(negedge clk);
        in_val = 1'b0; out_rdy = 1'b1;
        if (out_val && out_rdy) got.push_back(out_msg);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            in_val = 1'b0;
            tests++;
            if ({out_val, out_msg, out_last, occupancy, overflow} !== exp_vec()) begin
                failed++; $display("FAIL sim_cyc%0d act=%h exp=%h", c, {out_val, out_msg, out_last, occupancy, overflow}, exp_vec());
            end
            if (chk_next) begin
                chk_next = 1'b0;
                tests++; if ({occupancy, overflow} !== {OW'(2), 1'b0}) begin
                    failed++; $display("FAIL sim_accept act=%0d/%b exp=2/0", occupancy, overflow);
                end
            end
            if (!sent && midx == 3 && mq.size() == 2) begin
                set_bundle({8'h10, 8'h0F, 8'h0E, 8'h0D}); in_val = 1'b1;
                sent = 1'b1; chk_next = 1'b1;
            end
            if (out_val && out_rdy) got.push_back(out_msg);
        end
        tests++; if (!sent) begin failed++; $display("FAIL sim_window act=0 exp=1"); end
        tests++; if (got.size() != 12) begin failed++; $display("FAIL sim_count act=%0d exp=12", got.size()); end
        for (int i = 0; i < 12; i++) begin
            a = 'x; if (i < got.size()) a = got[i];
            tests++; if (a !== NB'(i < 8 ? i + 1 : i + 5)) begin
                failed++; $display("FAIL sim_elem%0d act=%h exp=%h", i, a, NB'(i < 8 ? i + 1 : i + 5));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] got[$];
        logic [NB-1:0] a;
        do_reset();
        @(negedge clk);
        set_bundle({8'h09, 8'h07, 8'h05, 8'h03}); in_val = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        in_val = 1'b0;
        tests++; if (out_msg !== 8'h03) begin failed++; $display("FAIL rmid_e0 act=%h exp=03", out_msg); end
        @(negedge clk);
        tests++; if (out_msg !== 8'h05) begin failed++; $display("FAIL rmid_e1 act=%h exp=05", out_msg); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tests++; if ({out_val, occupancy, overflow} !== '0) begin
            failed++; $display("FAIL rmid_clear act=%b/%0d/%b exp=0/0/0", out_val, occupancy, overflow);
        end
        set_bundle({8'h23, 8'h22, 8'h21, 8'h20}); in_val = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_val = 1'b0;
            tests++;
            if ({out_val, out_msg, out_last, occupancy, overflow} !== exp_vec()) begin
                failed++; $display("FAIL rmid_cyc%0d act=%h exp=%h", c, {out_val, out_msg, out_last, occupancy, overflow}, exp_vec());
            end
            if (out_val && out_rdy) got.push_back(out_msg);
        end
        tests++; if (got.size() != 4) begin failed++; $display("FAIL rmid_count act=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            a = 'x; if (i < got.size()) a = got[i];
            tests++; if (a !== NB'(8'h20 + i)) begin failed++; $display("FAIL rmid_elem%0d act=%h exp=%h", i, a, NB'(8'h20 + i)); end
        end
    endtask

    task automatic test_streaming();
        logic [NB-1:0] sent_q[$];
        logic [NB-1:0] got[$];
        logic [NB-1:0] a;
        bund_t b;
        int gaps = 0;
        do_reset();
        out_rdy = 1'b1;
        for (int j = 0; j <= 32; j++) begin
            @(negedge clk);
            in_val = 1'b0;
            tests++;
            if ({out_val, out_msg, out_last, occupancy, overflow} !== exp_vec()) begin
                failed++; $display("FAIL stream_cyc%0d act=%h exp=%h", j, {out_val, out_msg, out_last, occupancy, overflow}, exp_vec());
            end
            if (j >= 1 && (out_val !== 1'b1 || out_last !== ((j - 1) % 4 == 3))) gaps++;
            if (j % 4 == 0 && j < 32) begin
                for (int e = 0; e < 4; e++) b[e] = NB'($urandom);
                set_bundle(b); in_val = 1'b1;
                for (int e = 0; e < 4; e++) sent_q.push_back(b[e]);
            end
            if (out_val && out_rdy) got.push_back(out_msg);
        end
        tests++; if (gaps != 0) begin failed++; $display("FAIL stream_bubbles act=%0d exp=0", gaps); end
        tests++; if (got.size() != 32) begin failed++; $display("FAIL stream_count act=%0d exp=32", got.size()); end
        for (int i = 0; i < 32; i++) begin
            a = 'x; if (i < got.size()) a = got[i];
            tests++; if (a !== sent_q[i]) begin failed++; $display("FAIL stream_elem%0d act=%h exp=%h", i, a, sent_q[i]); end
        end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL stream_ovf act=%b exp=0", overflow); end
    endtask

    task automatic test_random();
        bund_t b;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            tests++;
            if ({out_val, out_msg, out_last, occupancy, overflow} !== exp_vec()) begin
                failed++; $display("FAIL rand_cyc%0d act=%h exp=%h", c, {out_val, out_msg, out_last, occupancy, overflow}, exp_vec());
            end
            for (int e = 0; e < 4; e++) b[e] = NB'($urandom);
            set_bundle(b);
            in_val  = ($urandom_range(0, 2) == 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        reset = 1'b1; in_val = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_simul_pop_push();
        test_reset_mid();
        test_streaming();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
